// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Bimodal direction predictor. It holds a table of 2^INDEX_BITS two-bit
// saturating counters (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T),
// indexed by pc[INDEX_BITS+1:2]. Upper PC bits are ignored, so aliasing
// between PCs is allowed.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   lookup_valid/_pc    fetch-stage prediction request
//   pred_valid/_taken   registered prediction, one cycle after the lookup
//   resolve_*           execute-stage outcome, used to train the table
//   mispredict          registered mispredict pulse, one cycle after resolve
//   bht_clear           restart a walk that sets every entry to 01
//   busy                high while the clear walk is running
//
// Optional feature: when the macro BRANCH_PREDICTOR_STATS_EN is defined, the
// free-running counters stat_lookups and stat_mispredicts are added. They are
// cleared by reset only, never by bht_clear.
//
// Reset puts the FSM in CLEAR with pointer 0. The table itself has no reset;
// the walk that follows reset initialises every entry.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_is_branch,
    input  logic        resolve_taken,
    input  logic        resolve_pred,
    output logic        mispredict,
    input  logic        bht_clear,
    output logic        busy
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
    logic [1:0]              bht_q [ENTRIES];

    logic [INDEX_BITS-1:0]   lookup_idx;
    logic [INDEX_BITS-1:0]   resolve_idx;
    logic                    update_en;
    logic [1:0]              cnt_cur;
    logic [1:0]              cnt_nxt;
    logic                    pred_valid_d, pred_taken_d, mispredict_d;
    logic                    unused_pc_bits;

    assign lookup_idx  = lookup_pc[INDEX_BITS+1:2];
    assign resolve_idx = resolve_pc[INDEX_BITS+1:2];

    // Only the index bits of the PCs take part in the design.
    assign unused_pc_bits = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                              resolve_pc[31:INDEX_BITS+2], resolve_pc[1:0]};

    assign busy = (state_q == CLEAR);

    // ---------------- clear-walk FSM ----------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (bht_clear) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (bht_clear) begin
                    // A fresh request restarts the walk from entry 0.
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + INDEX_BITS'(1);
                    if (ptr_q == '1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- counter update ----------------
    assign update_en = resolve_valid & resolve_is_branch & (state_q == IDLE);
    assign cnt_cur   = bht_q[resolve_idx];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (resolve_taken) begin
            if (cnt_cur != 2'b11) begin
                cnt_nxt = cnt_cur + 2'd1;
            end
        end else begin
            if (cnt_cur != 2'b00) begin
                cnt_nxt = cnt_cur - 2'd1;
            end
        end
    end

    // The walk has priority; training is dropped while it runs.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            bht_q[ptr_q] <= 2'b01;
        end else if (update_en) begin
            bht_q[resolve_idx] <= cnt_nxt;
        end
    end

    // ---------------- registered outputs ----------------
    // The table read samples the pre-edge contents, which gives
    // read-before-write on a same-cycle lookup and update.
    assign pred_valid_d = lookup_valid;
    assign pred_taken_d = lookup_valid & (state_q == IDLE) & bht_q[lookup_idx][1];
    assign mispredict_d = resolve_valid & resolve_is_branch &
                          (resolve_taken != resolve_pred);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            pred_valid <= pred_valid_d;
            pred_taken <= pred_taken_d;
            mispredict <= mispredict_d;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups     <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_lookups     <= stat_lookups + 32'(lookup_valid);
            stat_mispredicts <= stat_mispredicts + 32'(mispredict);
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor with INDEX_BITS = 6. Inputs are
// driven on the falling edge, and outputs are sampled on the next falling
// edge, after the rising edge that registers them. A table of directed
// vectors covers training, saturation, mispredict and aliasing. Hand-written
// sequences cover reset, the clear walk and restarting the walk. Statistics
// checks are compiled in with BRANCH_PREDICTOR_STATS_EN.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_is_branch;
    logic        resolve_taken;
    logic        resolve_pred;
    logic        mispredict;
    logic        bht_clear;
    logic        busy;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .pred_valid        (pred_valid),
        .pred_taken        (pred_taken),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_is_branch (resolve_is_branch),
        .resolve_taken     (resolve_taken),
        .resolve_pred      (resolve_pred),
        .mispredict        (mispredict),
        .bht_clear         (bht_clear),
        .busy              (busy)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_lookups      (stat_lookups),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        rv;
        logic [31:0] rpc;
        logic        rib;
        logic        rt;
        logic        rp;
        logic        clr;
        logic        pv;
        logic        pt;
        logic        mp;
        logic        bsy;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_idle();
        lookup_valid      = 1'b0;
        lookup_pc         = '0;
        resolve_valid     = 1'b0;
        resolve_pc        = '0;
        resolve_is_branch = 1'b0;
        resolve_taken     = 1'b0;
        resolve_pred      = 1'b0;
        bht_clear         = 1'b0;
    endtask

    task automatic lookup_check(input logic [31:0] pc, input logic exp_pt, input string name);
        drive_idle();
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        tick();
        chk({name, " pred_valid"}, 32'(pred_valid), 32'd1);
        chk({name, " pred_taken"}, 32'(pred_taken), 32'(exp_pt));
    endtask

    // Counts falling-edge samples with busy high, starting with the current
    // one. Once a rising edge inside the walk has passed, pred_taken must be 0
    // and pred_valid must follow lookup_valid.
    task automatic count_busy(input bit chk_pred, output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            if (chk_pred && n > 0) begin
                chk("walk pred_taken", 32'(pred_taken), 32'd0);
                chk("walk pred_valid", 32'(pred_valid), 32'(lookup_valid));
            end
            n++;
            tick();
        end
    endtask

    initial begin
        int n;

        //                lv   lpc           rv   rpc           rib  rt   rp   clr  pv   pt   mp   bsy
        vecs[0]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}; // e0 -> 10
        vecs[2]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}; // e0 -> 11
        vecs[3]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}; // e0 stays 11
        vecs[5]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0100, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0}; // e0 -> 10
        vecs[6]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[7]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0}; // 0x200 aliases e0 -> 11
        vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0200, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0}; // not a branch
        vecs[10] = '{1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b1, 32'h0000_0104, 1'b1, 32'h0000_0104, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0}; // e1 01 -> 10
        vecs[12] = '{1'b1, 32'h0000_0104, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
        vecs[13] = '{1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0}; // e1 -> 01
        vecs[14] = '{1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0}; // e1 -> 00
        vecs[15] = '{1'b0, 32'h0,         1'b1, 32'h0000_0104, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0}; // e1 stays 00
        vecs[16] = '{1'b1, 32'h0000_0104, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b1, 32'h0000_0104, 1'b1, 32'h0000_0104, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0}; // e1 -> 01
        vecs[18] = '{1'b1, 32'h0000_0104, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
        vecs[19] = '{1'b1, 32'h0000_0144, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0}; // e17 untouched
        vecs[20] = '{1'b1, 32'h0000_1100, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0}; // aliases e0 (11)
        vecs[21] = '{1'b0, 32'h0000_0100, 1'b0, 32'h0,         1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        chk("reset pred_valid", 32'(pred_valid), 32'd0);
        chk("reset pred_taken", 32'(pred_taken), 32'd0);
        chk("reset mispredict", 32'(mispredict), 32'd0);
        chk("reset busy",       32'(busy),       32'd1);

        // A reset in the middle of the walk restarts it.
        rst_n = 1'b1;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        repeat (10) tick();
        chk("midwalk busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midwalk reset busy",       32'(busy),       32'd1);
        chk("midwalk reset pred_valid", 32'(pred_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full walk with lookups held at 0x100.
        count_busy(1'b1, n);
        chk("reset walk length", 32'(n), 32'd64);
        chk("post walk pred_taken", 32'(pred_taken), 32'd0);
        lookup_check(32'h100, 1'b0, "post walk lookup 0x100");

        // ---------------- vector table ----------------
        for (int i = 0; i < NVEC; i++) begin
            lookup_valid      = vecs[i].lv;
            lookup_pc         = vecs[i].lpc;
            resolve_valid     = vecs[i].rv;
            resolve_pc        = vecs[i].rpc;
            resolve_is_branch = vecs[i].rib;
            resolve_taken     = vecs[i].rt;
            resolve_pred      = vecs[i].rp;
            bht_clear         = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d pred_valid", i), 32'(pred_valid), 32'(vecs[i].pv));
            chk($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].pt));
            chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].mp));
            chk($sformatf("vec%0d busy", i),       32'(busy),       32'(vecs[i].bsy));
        end

        // ---------------- clear from IDLE with trained entries ----------------
        drive_idle();
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        bht_clear    = 1'b1;
        tick();
        bht_clear = 1'b0;
        count_busy(1'b1, n);
        chk("clear walk length", 32'(n), 32'd64);
        lookup_check(32'h100, 1'b0, "after clear 0x100");
        lookup_check(32'h200, 1'b0, "after clear 0x200");
        lookup_check(32'h104, 1'b0, "after clear 0x104");

        // A resolve during the walk must not train the table.
        drive_idle();
        bht_clear = 1'b1;
        tick();
        bht_clear         = 1'b0;
        resolve_valid     = 1'b1;
        resolve_pc        = 32'h100;
        resolve_is_branch = 1'b1;
        resolve_taken     = 1'b1;
        resolve_pred      = 1'b0;
        repeat (29) tick();
        chk("mispredict during walk", 32'(mispredict), 32'd1);
        drive_idle();
        tick();
        // Pointer is now 30; re-request the clear.
        chk("busy at ptr 30", 32'(busy), 32'd1);
        bht_clear = 1'b1;
        tick();
        bht_clear = 1'b0;
        count_busy(1'b0, n);
        chk("restart walk length", 32'(n), 32'd64);
        lookup_check(32'h100, 1'b0, "after restart 0x100");

`ifdef BRANCH_PREDICTOR_STATS_EN
        // ---------------- statistics ----------------
        drive_idle();
        rst_n = 1'b0;
        #1;
        chk("stat reset lookups",     stat_lookups,     32'd0);
        chk("stat reset mispredicts", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, n);
        for (int i = 0; i < 10; i++) begin
            lookup_valid = 1'b1;
            lookup_pc    = 32'(i * 4);
            tick();
        end
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            resolve_valid     = 1'b1;
            resolve_pc        = 32'h200;
            resolve_is_branch = 1'b1;
            resolve_taken     = 1'b1;
            resolve_pred      = 1'b0;
            tick();
        end
        drive_idle();
        tick();
        tick();
        chk("stat lookups",     stat_lookups,     32'd10);
        chk("stat mispredicts", stat_mispredicts, 32'd3);
        bht_clear = 1'b1;
        tick();
        bht_clear = 1'b0;
        count_busy(1'b0, n);
        tick();
        chk("stat lookups after clear",     stat_lookups,     32'd10);
        chk("stat mispredicts after clear", stat_mispredicts, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
